mmio_counter_bridge: RTL and testbench

- Sits between the MEM-stage data-memory port and the data cache.
- Decodes CPU data accesses. Addresses in the performance-counter window (16'hFFEE–16'hFFFE, even addresses) are routed to the counter block as counter_read/counter_write with a counter_address. All other addresses pass through to the dcache unchanged.
- It is the initiator/reader end of the counter interface: it generates single-cycle write-clear strobes, samples counter_data into a response register, and returns a standard mem_resp handshake to the pipeline.

---
 rtl/lc3b_types.sv | 18 +
 rtl/mmio_counter_bridge_if.sv | 25 ++
 rtl/mmio_counter_bridge_decode.sv | 21 ++
 rtl/mmio_counter_bridge.sv | 128 ++++++++++++
 tb/tb_mmio_counter_bridge.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types and the MMIO counter-bridge constants.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    localparam lc3b_word lc3b_ctr_base = 16'hFFEE;
    localparam int lc3b_ctr_count = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CACHE,
        ST_CTR_RD,
        ST_CTR_WR,
        ST_CTR_RESP,
        ST_DRAIN
    } mmio_bridge_state_t;

endpackage

// File: rtl/mmio_counter_bridge_if.sv
// CPU-side data-memory port (MEM stage <-> bridge).
interface mmio_counter_bridge_if;
    import lc3b_types::*;

    logic     mem_read;
    logic     mem_write;
    lc3b_word mem_address;
    lc3b_word mem_wdata;
    logic [1:0] mem_byte_enable;
    logic     mem_resp;
    lc3b_word mem_rdata;

    modport master (
        output mem_read, mem_write, mem_address,
        output mem_wdata, mem_byte_enable,
        input  mem_resp, mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_address,
        input  mem_wdata, mem_byte_enable,
        output mem_resp, mem_rdata
    );

endinterface

// File: rtl/mmio_counter_bridge_decode.sv
// Combinational address-window decode for word-addressed MMIO devices.
module mmio_window_decode
    import lc3b_types::*;
#(
    parameter lc3b_word BASE  = lc3b_ctr_base,
    parameter int       COUNT = lc3b_ctr_count
) (
    input  lc3b_word addr,
    output logic     in_win,
    output lc3b_word masked
);

    // 17-bit upper bound so a window touching 16'hFFFF never wraps
    localparam logic [16:0] LAST = {1'b0, BASE} + 17'(2 * (COUNT - 1));

    always_comb begin
        masked = addr & 16'hFFFE;
        in_win = (masked >= BASE) && ({1'b0, masked} <= LAST);
    end

endmodule

// File: rtl/mmio_counter_bridge.sv
// Routes MEM-stage accesses to the perf-counter block or the dcache.
module mmio_counter_bridge
    import lc3b_types::*;
#(
    parameter lc3b_word CTR_BASE    = lc3b_ctr_base,
    parameter int       CTR_COUNT   = lc3b_ctr_count,
    parameter int       CTR_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mmio_counter_bridge_if.slave        mem,
    output logic                        dcache_read,
    output logic                        dcache_write,
    output lc3b_word                    dcache_address,
    output lc3b_word                    dcache_wdata,
    output logic [1:0]                  dcache_byte_enable,
    input  logic                        dcache_resp,
    input  lc3b_word                    dcache_rdata,
    output logic                        counter_read,
    output logic                        counter_write,
    output lc3b_word                    counter_address,
    input  lc3b_word                    counter_data
);

    localparam logic [1:0] LAST_WAIT = 2'(CTR_LATENCY - 1);

    mmio_bridge_state_t state_q, state_d;
    logic [1:0] wait_q, wait_d;
    lc3b_word   rdata_q, rdata_d;
    lc3b_word   addr_q, addr_d;

    logic     in_win;
    lc3b_word masked;
    logic     req;
    logic     fwd;
    logic     ctr_st;

    mmio_window_decode #(
        .BASE  (CTR_BASE),
        .COUNT (CTR_COUNT)
    ) u_decode (
        .addr   (mem.mem_address),
        .in_win (in_win),
        .masked (masked)
    );

    always_comb begin
        req    = mem.mem_read | mem.mem_write;
        fwd    = ((state_q == ST_IDLE) && req && !in_win) ||
                 (state_q == ST_CACHE);
        ctr_st = (state_q == ST_CTR_RD) || (state_q == ST_CTR_WR) ||
                 (state_q == ST_CTR_RESP);
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req && !in_win) begin
                    state_d = dcache_resp ? ST_DRAIN : ST_CACHE;
                end else if (mem.mem_read && in_win) begin
                    state_d = ST_CTR_RD;
                    addr_d  = masked;
                    wait_d  = '0;
                end else if (mem.mem_write && in_win) begin
                    state_d = ST_CTR_WR;
                    addr_d  = masked;
                    rdata_d = '0;
                end
            end
            ST_CACHE: begin
                if (dcache_resp) state_d = ST_DRAIN;
            end
            ST_CTR_RD: begin
                if (wait_q == LAST_WAIT) begin
                    rdata_d = counter_data;
                    wait_d  = '0;
                    state_d = ST_CTR_RESP;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_CTR_WR:   state_d = ST_CTR_RESP;
            ST_CTR_RESP: state_d = ST_DRAIN;
            ST_DRAIN:    state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
        end
    end

    // Cache path is a straight wire; counter strobes come from state flops
    always_comb begin
        dcache_read        = fwd & mem.mem_read;
        dcache_write       = fwd & mem.mem_write & ~mem.mem_read;
        dcache_address     = ctr_st ? addr_q :
                             (in_win ? masked : mem.mem_address);
        dcache_wdata       = mem.mem_wdata;
        dcache_byte_enable = mem.mem_byte_enable;
        counter_read       = (state_q == ST_CTR_RD);
        counter_write      = (state_q == ST_CTR_WR);
        counter_address    = addr_q;
        mem.mem_resp       = (state_q == ST_CTR_RESP) | (fwd & dcache_resp);
        if (state_q == ST_CTR_RESP) begin
            mem.mem_rdata = rdata_q;
        end else if (state_q == ST_CACHE || (fwd && dcache_resp)) begin
            mem.mem_rdata = dcache_rdata;
        end else begin
            mem.mem_rdata = '0;
        end
    end

endmodule

// File: tb/tb_mmio_counter_bridge.sv
// Directed bench for mmio_counter_bridge at CTR_LATENCY 1 and 3.
module tb_mmio_counter_bridge;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    mmio_counter_bridge_if if1 ();
    mmio_counter_bridge_if if3 ();

    logic       dc_rd1, dc_wr1, dc_resp1, cr1, cw1;
    lc3b_word   dc_addr1, dc_wdata1, dc_rdata1, ca1, cd1;
    logic [1:0] dc_be1;
    logic       dc_rd3, dc_wr3, dc_resp3, cr3, cw3;
    lc3b_word   dc_addr3, dc_wdata3, dc_rdata3, ca3, cd3;
    logic [1:0] dc_be3;
    lc3b_word   extra3;

    // Counter block model: value derived from the selected address
    function automatic lc3b_word cmodel(lc3b_word a);
        return a ^ 16'hFFB6;
    endfunction

    assign cd1 = cmodel(ca1);
    assign cd3 = cmodel(ca3) + extra3;

    mmio_counter_bridge #(.CTR_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem(if1),
        .dcache_read(dc_rd1), .dcache_write(dc_wr1),
        .dcache_address(dc_addr1), .dcache_wdata(dc_wdata1),
        .dcache_byte_enable(dc_be1), .dcache_resp(dc_resp1),
        .dcache_rdata(dc_rdata1), .counter_read(cr1),
        .counter_write(cw1), .counter_address(ca1),
        .counter_data(cd1)
    );

    mmio_counter_bridge #(.CTR_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mem(if3),
        .dcache_read(dc_rd3), .dcache_write(dc_wr3),
        .dcache_address(dc_addr3), .dcache_wdata(dc_wdata3),
        .dcache_byte_enable(dc_be3), .dcache_resp(dc_resp3),
        .dcache_rdata(dc_rdata3), .counter_read(cr3),
        .counter_write(cw3), .counter_address(ca3),
        .counter_data(cd3)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic req1(logic rd, logic wr, lc3b_word a);
        if1.mem_read = rd;
        if1.mem_write = wr;
        if1.mem_address = a;
        if1.mem_wdata = 16'h1234;
        if1.mem_byte_enable = 2'b11;
    endtask

    task automatic req3(logic rd, logic wr, lc3b_word a);
        if3.mem_read = rd;
        if3.mem_write = wr;
        if3.mem_address = a;
        if3.mem_wdata = 16'h0;
        if3.mem_byte_enable = 2'b11;
    endtask

    int nw, nr;

    initial begin
        req1(0, 0, 0);
        req3(0, 0, 0);
        dc_resp1 = 0; dc_rdata1 = 0;
        dc_resp3 = 0; dc_rdata3 = 0;
        extra3 = 0;
        #12;
        check("rst_resp", 32'(if1.mem_resp), 0);
        check("rst_cr", 32'(cr1), 0);
        check("rst_cw", 32'(cw1), 0);
        check("rst_dcrd", 32'(dc_rd1), 0);
        check("rst_dcwr", 32'(dc_wr1), 0);
        check("rst_rdata", 32'(if1.mem_rdata), 0);
        smp();
        rst_n = 1'b1;

        // dcache read, response on cycle 3
        cyc(); req1(1, 0, 16'h1234); smp();
        check("c_dcrd0", 32'(dc_rd1), 1);
        check("c_addr0", 32'(dc_addr1), 32'h1234);
        check("c_resp0", 32'(if1.mem_resp), 0);
        check("c_cr0", 32'(cr1), 0);
        for (int i = 1; i < 3; i++) begin
            cyc(); smp();
            check("c_resp_wait", 32'(if1.mem_resp), 0);
            check("c_cr_wait", 32'(cr1), 0);
            check("c_dcrd_wait", 32'(dc_rd1), 1);
        end
        cyc(); dc_resp1 = 1; dc_rdata1 = 16'hBEEF; smp();
        check("c_resp3", 32'(if1.mem_resp), 1);
        check("c_rdata3", 32'(if1.mem_rdata), 32'hBEEF);
        cyc(); req1(0, 0, 0); dc_resp1 = 0; smp();
        check("c_drain_resp", 32'(if1.mem_resp), 0);
        cyc();

        // counter read, latency 1
        cyc(); req1(1, 0, 16'hFFF4); smp();
        check("r_cr0", 32'(cr1), 0);
        check("r_dcrd0", 32'(dc_rd1), 0);
        cyc(); smp();
        check("r_cr1", 32'(cr1), 1);
        check("r_ca1", 32'(ca1), 32'hFFF4);
        check("r_dcrd1", 32'(dc_rd1), 0);
        check("r_resp1", 32'(if1.mem_resp), 0);
        cyc(); smp();
        check("r_resp2", 32'(if1.mem_resp), 1);
        check("r_rdata2", 32'(if1.mem_rdata), 32'h0042);
        check("r_cr2", 32'(cr1), 0);
        cyc(); req1(0, 0, 0); smp();
        check("r_drain", 32'(if1.mem_resp), 0);
        cyc();

        // counter clear, request held four cycles
        nw = 0; nr = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i == 0) req1(0, 1, 16'hFFFE);
            if (i == 4) req1(0, 0, 0);
            smp();
            nw += int'(cw1);
            nr += int'(if1.mem_resp);
            if (i == 1) begin
                check("w_cw1", 32'(cw1), 1);
                check("w_ca1", 32'(ca1), 32'hFFFE);
            end
            if (i == 2) check("w_rdata", 32'(if1.mem_rdata), 0);
        end
        check("w_cw_count", 32'(nw), 1);
        check("w_resp_count", 32'(nr), 1);

        // odd address maps down into the window
        cyc(); req1(1, 0, 16'hFFEF); smp();
        cyc(); smp();
        check("o_cr", 32'(cr1), 1);
        check("o_ca", 32'(ca1), 32'hFFEE);
        cyc(); smp();
        check("o_rdata", 32'(if1.mem_rdata), 32'h0058);
        cyc(); req1(0, 0, 0); smp();
        cyc();

        // just below the window goes to the dcache
        cyc(); req1(1, 0, 16'hFFEC); smp();
        check("b_dcrd", 32'(dc_rd1), 1);
        check("b_addr", 32'(dc_addr1), 32'hFFEC);
        check("b_cr", 32'(cr1), 0);
        cyc(); dc_resp1 = 1; dc_rdata1 = 16'h5A5A; smp();
        check("b_resp", 32'(if1.mem_resp), 1);
        check("b_rdata", 32'(if1.mem_rdata), 32'h5A5A);
        check("b_cr1", 32'(cr1), 0);
        cyc(); req1(0, 0, 0); dc_resp1 = 0; smp();
        cyc();

        // read and write together behave as a read
        cyc(); req1(1, 1, 16'hFFF2); smp();
        check("rw_dcwr", 32'(dc_wr1), 0);
        cyc(); smp();
        check("rw_cr", 32'(cr1), 1);
        check("rw_cw", 32'(cw1), 0);
        cyc(); smp();
        check("rw_resp", 32'(if1.mem_resp), 1);
        check("rw_rdata", 32'(if1.mem_rdata), 32'h0044);
        cyc(); req1(0, 0, 0); smp();
        cyc();

        // async reset during a counter read
        cyc(); req1(1, 0, 16'hFFF4); smp();
        cyc(); smp();
        check("x_cr_pre", 32'(cr1), 1);
        #1 rst_n = 1'b0;
        #1;
        check("x_cr_rst", 32'(cr1), 0);
        check("x_resp_rst", 32'(if1.mem_resp), 0);
        check("x_ca_rst", 32'(ca1), 0);
        req1(0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(); smp();
            check("x_resp_hold", 32'(if1.mem_resp), 0);
        end
        rst_n = 1'b1;
        cyc(); req1(0, 1, 16'hFFF0); smp();
        cyc(); smp();
        check("x_cw", 32'(cw1), 1);
        check("x_ca", 32'(ca1), 32'hFFF0);
        cyc(); smp();
        check("x_resp", 32'(if1.mem_resp), 1);
        check("x_rdata", 32'(if1.mem_rdata), 0);
        cyc(); req1(0, 0, 0); smp();
        cyc();

        // latency 3: only the third read cycle sees clean data
        cyc(); req3(1, 0, 16'hFFFA); extra3 = 16'h0100; smp();
        check("l3_cr0", 32'(cr3), 0);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            extra3 = (i == 3) ? 16'h0000 : 16'h0100;
            smp();
            check("l3_cr", 32'(cr3), 1);
            check("l3_ca", 32'(ca3), 32'hFFFA);
            check("l3_resp_wait", 32'(if3.mem_resp), 0);
        end
        cyc(); extra3 = 16'h0200; smp();
        check("l3_resp", 32'(if3.mem_resp), 1);
        check("l3_rdata", 32'(if3.mem_rdata), 32'h004C);
        check("l3_cr4", 32'(cr3), 0);
        cyc(); req3(0, 0, 0); extra3 = 0; smp();
        check("l3_drain", 32'(if3.mem_resp), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
